// File: rtl/lcd_power_sequencer_pkg.sv
// lcd_power_sequencer_pkg: state encoding shared by the power sequencer files
package lcd_power_sequencer_pkg;
  typedef enum logic [2:0] {OFF, TIMING_UP, WAIT_FRAME, ON, BL_DOWN} state_t;
endpackage

// File: rtl/lcd_power_sequencer_if.sv
// lcd_power_sequencer_if: control/status bundle between the panel controller and the sequencer
interface lcd_power_sequencer_if #(parameter int w_bright = 8);
  logic                enable;
  logic [w_bright-1:0] brightness;
  logic                frame_start;
  logic                timing_en;
  logic                bl_pwm;
  logic                ready;
  logic                busy;
  modport master (output enable, brightness, frame_start, input timing_en, bl_pwm, ready, busy);
  modport slave (input enable, brightness, frame_start, output timing_en, bl_pwm, ready, busy);
endinterface

// File: rtl/lcd_bl_pwm.sv
// lcd_bl_pwm: free-running backlight PWM with duty latched only at period wrap
module lcd_bl_pwm #(
  parameter int w_bright = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [w_bright-1:0] brightness,
  output logic                pwm
);
  logic [w_bright-1:0] cnt_q, cnt_d, duty_q, duty_d;
  logic                pwm_q, pwm_d;
  // next counter, duty taken only at all-ones so a period never changes mid-way
  always_comb begin
    cnt_d  = cnt_q + w_bright'(1);
    duty_d = (&cnt_q) ? brightness : duty_q;
    pwm_d  = en && (cnt_q < duty_q);
  end
  // counter, duty and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end
  assign pwm = pwm_q;
endmodule

// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer: orders timing enable, panel settle delay, frame alignment and backlight
module lcd_power_sequencer
  import lcd_power_sequencer_pkg::*;
#(
  parameter int clk_mhz  = 33,
  parameter int t_on_us  = 10000,
  parameter int t_off_us = 10000,
  parameter int w_bright = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  lcd_power_sequencer_if.slave bus
);
  localparam int n_on  = t_on_us * clk_mhz;
  localparam int n_off = t_off_us * clk_mhz;
  localparam int n_max = (n_on > n_off) ? n_on : n_off;
  localparam int cnt_w = $clog2(n_max + 1);
  state_t             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic               pwm_en;
  // next state; the delay counter restarts from zero whenever the state changes
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:        state_d = bus.enable ? TIMING_UP : OFF;
      TIMING_UP:  state_d = !bus.enable ? OFF : (cnt_q == cnt_w'(n_on - 1)) ? WAIT_FRAME : TIMING_UP;
      WAIT_FRAME: state_d = !bus.enable ? OFF : bus.frame_start ? ON : WAIT_FRAME;
      ON:         state_d = bus.enable ? ON : BL_DOWN;
      BL_DOWN:    state_d = (cnt_q == cnt_w'(n_off - 1)) ? OFF : BL_DOWN;
      default:    state_d = OFF;
    endcase
    cnt_d = (state_d == state_q && (state_q == TIMING_UP || state_q == BL_DOWN)) ? cnt_q + cnt_w'(1) : '0;
  end
  // state and delay counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // gate on the next state so the backlight is dark in the very first BL_DOWN cycle
  assign pwm_en        = (state_d == ON);
  assign bus.timing_en = (state_q != OFF);
  assign bus.ready     = (state_q == ON);
  assign bus.busy      = (state_q == TIMING_UP) || (state_q == WAIT_FRAME) || (state_q == BL_DOWN);
  lcd_bl_pwm #(.w_bright(w_bright)) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (pwm_en),
    .brightness (bus.brightness),
    .pwm        (bus.bl_pwm)
  );
endmodule

// File: tb/tb_lcd_power_sequencer.sv
// tb_lcd_power_sequencer: directed vector bench for the LCD power sequencer
module tb_lcd_power_sequencer;
  typedef struct packed {
    logic en;
    logic fs;
    logic te;
    logic rdy;
    logic bsy;
    logic pc;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   nv = 0;
  int   hi;
  vec_t vec[32];
  lcd_power_sequencer_if #(.w_bright(4)) bus ();
  lcd_power_sequencer #(.clk_mhz(1), .t_on_us(4), .t_off_us(3), .w_bright(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input logic en, input logic fs, input logic te, input logic rdy, input logic bsy, input logic pc);
    vec[nv] = '{en, fs, te, rdy, bsy, pc};
    nv++;
  endtask
  task automatic run(input int lo, input int hi_idx);
    for (int i = lo; i <= hi_idx; i++) begin
      bus.enable = vec[i].en;
      bus.frame_start = vec[i].fs;
      step();
      chk($sformatf("vec%0d timing_en", i), int'(bus.timing_en), int'(vec[i].te));
      chk($sformatf("vec%0d ready", i), int'(bus.ready), int'(vec[i].rdy));
      chk($sformatf("vec%0d busy", i), int'(bus.busy), int'(vec[i].bsy));
      if (vec[i].pc) chk($sformatf("vec%0d bl_pwm", i), int'(bus.bl_pwm), 0);
    end
    bus.frame_start = 1'b0;
  endtask
  task automatic count_hi(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      step();
      h += int'(bus.bl_pwm);
    end
  endtask
  task automatic wait_pwm(input bit rise, input string nm);
    logic prev;
    bit found;
    prev = bus.bl_pwm;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (bus.bl_pwm && (!rise || !prev)) found = 1;
      prev = bus.bl_pwm;
    end
    chk(nm, int'(found), 1);
  endtask
  initial begin
    // power-up sequence, frame_start ignored in TIMING_UP, accepted at cycle 8
    add(1, 0, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 1, 1, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0);
    // power-down with enable re-raised inside BL_DOWN, then restart
    add(0, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 1, 0, 0);
    // short enable pulse aborts, frame_start in OFF ignored, full restart
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 0, 1, 1);
    add(1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 1, 0, 0);
    bus.enable = 1'b0;
    bus.frame_start = 1'b0;
    bus.brightness = 4'd4;
    step();
    step();
    chk("rst timing_en", int'(bus.timing_en), 0);
    chk("rst bl_pwm", int'(bus.bl_pwm), 0);
    chk("rst ready", int'(bus.ready), 0);
    chk("rst busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    run(0, 9);
    step();
    repeat (16) step();
    count_hi(16, hi);
    chk("duty4 highs", hi, 4);
    wait_pwm(1, "duty4 rise");
    bus.brightness = 4'd12;
    count_hi(15, hi);
    chk("old duty kept", hi, 3);
    count_hi(16, hi);
    chk("duty12 highs", hi, 12);
    bus.brightness = 4'd0;
    repeat (17) step();
    count_hi(16, hi);
    chk("duty0 highs", hi, 0);
    bus.brightness = 4'd15;
    repeat (17) step();
    count_hi(16, hi);
    chk("duty15 highs", hi, 15);
    wait_pwm(0, "pwm high before off");
    run(10, 19);
    bus.enable = 1'b0;
    repeat (5) step();
    chk("off timing_en", int'(bus.timing_en), 0);
    run(20, 31);
    wait_pwm(0, "pwm high before reset");
    chk("on ready", int'(bus.ready), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async bl_pwm", int'(bus.bl_pwm), 0);
    chk("async timing_en", int'(bus.timing_en), 0);
    chk("async ready", int'(bus.ready), 0);
    chk("async busy", int'(bus.busy), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("resume timing_en", int'(bus.timing_en), 1);
    chk("resume busy", int'(bus.busy), 1);
    chk("resume ready", int'(bus.ready), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_power_sequencer.md
LCD_POWER_SEQUENCER -- requirements
Module: lcd_power_sequencer

Interface
REQ-001 Parameter clk_mhz, default 33: clock frequency in MHz.
REQ-002 Parameter t_on_us, default 10000: delay from timing enable to backlight-eligible, in microseconds.
REQ-003 Parameter t_off_us, default 10000: delay from backlight off to timing disable, in microseconds.
REQ-004 Parameter w_bright, default 8: brightness and PWM width.
REQ-005 Port clk, input, 1: single clock (LCD pixel clock domain).
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port enable, input, 1: level request, panel on (1) or off (0).
REQ-008 Port brightness, input, w_bright: backlight duty, 0 = dark, all-ones = maximum.
REQ-009 Port frame_start, input, 1: one-cycle pulse at frame start, taken from the timing generator vsync edge.
REQ-010 Port timing_en, output, 1: active-high run enable for the LCD timing generator (drives its active-low reset through an inverter outside this block).
REQ-011 Port bl_pwm, output, 1: registered backlight PWM output.
REQ-012 Port ready, output, 1: high only in state ON.
REQ-013 Port busy, output, 1: high in TIMING_UP, WAIT_FRAME and BL_DOWN.

Function
REQ-014 FSM states SHALL be OFF, TIMING_UP, WAIT_FRAME, ON and BL_DOWN.
REQ-015 OFF with enable=1 -> TIMING_UP on the next edge; timing_en=1 from that cycle onward.
REQ-016 TIMING_UP SHALL last exactly N_ON = t_on_us*clk_mhz cycles, then go to WAIT_FRAME.
REQ-017 WAIT_FRAME: frame_start=1 in cycle N -> ON in cycle N+1.
REQ-018 ON with enable=0 -> BL_DOWN; bl_pwm=0 from the first BL_DOWN cycle.
REQ-019 BL_DOWN SHALL last exactly N_OFF = t_off_us*clk_mhz cycles with timing_en=1, then go to OFF with timing_en=0.
REQ-020 enable=0 in TIMING_UP or WAIT_FRAME -> OFF directly; the delay counter is cleared.
REQ-021 enable=1 during BL_DOWN SHALL be ignored until OFF is reached; if enable is still 1 in OFF, the normal restart (REQ-015) follows.
REQ-022 frame_start SHALL be ignored outside WAIT_FRAME.
REQ-023 The delay counter width SHALL be $clog2(max(N_ON,N_OFF)+1) and it SHALL reload to 0 on every state entry.
REQ-024 The PWM counter SHALL be w_bright bits, free-running, and wrap from all-ones to 0.
REQ-025 brightness SHALL be latched into a duty register only when the PWM counter equals all-ones, so no mid-period glitch is possible.
REQ-026 In ON, bl_pwm SHALL equal (pwm_cnt < duty), registered one cycle; in all other states bl_pwm=0.
REQ-027 If duty=0, bl_pwm SHALL stay constantly 0; if duty=all-ones, bl_pwm SHALL be low exactly 1 cycle per 2^w_bright.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=OFF, timing_en=0, bl_pwm=0, ready=0, busy=0, and all counters and duty to 0.
REQ-029 Reset asserted mid-sequence SHALL abort immediately, with no BL_DOWN delay; after release, normal operation resumes from OFF.

Structure
REQ-030 Package lcd_power_sequencer_pkg SHALL hold the state enum typedef only; delay constants are local to the module.
REQ-031 PWM counter, duty latch and compare SHALL form one sub-module, lcd_bl_pwm (inputs: clk, rst_n, en, brightness; output: pwm).

Verification
The bench SHALL use clk_mhz=1, t_on_us=4, t_off_us=3, w_bright=4.
REQ-032 Reset release then enable=1 at cycle 0 -> timing_en=1 at cycle 1, WAIT_FRAME at cycle 5; frame_start at cycle 8 -> ready=1 at cycle 9.
REQ-033 In ON with brightness=4 -> bl_pwm high 4 of every 16 cycles; brightness changed to 12 mid-period -> new duty only after the next wrap.
REQ-034 enable=0 in ON -> bl_pwm=0 next cycle, timing_en stays 1 for 3 cycles then 0; enable re-raised inside BL_DOWN -> OFF, then TIMING_UP on the following cycle.
REQ-035 enable pulsed high for 2 cycles (drops in TIMING_UP) -> timing_en returns to 0, busy=0, ready never asserts; frame_start pulses while in OFF have no effect.
REQ-036 rst_n=0 asynchronously in ON (between clock edges) -> bl_pwm, timing_en and ready drop to 0 without waiting for a clock edge.
REQ-037 brightness=0 and brightness=15 in ON -> bl_pwm constantly 0, and low exactly once per 16 cycles, respectively.
